// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-flop synchroniser, 3-sample mid-bit majority vote,
// optional parity, 1/2 stop bits, valid/ready delivery with overrun detection.
module uart_rx_cfg #(
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 soft_rst,
    input  logic                 rx_in,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 rx_busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W = $clog2(DATA_BITS) + 1;
    localparam int unsigned MID   = CLKS_PER_BIT / 2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(MID - 1);
    localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(MID);
    localparam logic [CNT_W-1:0] CNT_DEC  = CNT_W'(MID + 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic             PAR_ODD  = (PARITY == 1);
    localparam logic             PAR_EN   = (PARITY != 0);
    localparam logic             TWO_STOP = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_e;

    state_e               state_q;
    logic                 rx_meta_q;
    logic                 rx_s_q;
    logic [CNT_W-1:0]     clk_cnt_q;
    logic [BIT_W-1:0]     bit_cnt_q;
    logic [1:0]           samp_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_q;
    logic                 stop_idx_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 parity_err_q;
    logic                 frame_err_q;
    logic                 overrun_q;

    logic vote_d;
    logic decide_d;
    logic bit_end_d;
    logic last_stop_d;
    logic perr_d;
    logic frame_done_d;

    // Bit decision and completion qualifiers
    always_comb begin
        vote_d       = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);
        decide_d     = (clk_cnt_q == CNT_DEC);
        bit_end_d    = (clk_cnt_q == CNT_LAST);
        last_stop_d  = !TWO_STOP || stop_idx_q;
        perr_d       = PAR_EN && ((^shift_q ^ par_q) != PAR_ODD);
        frame_done_d = (state_q == S_STOP) && decide_d && vote_d && last_stop_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            clk_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            samp_q       <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            stop_idx_q   <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else if (soft_rst) begin
            state_q      <= S_IDLE;
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            clk_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            samp_q       <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            stop_idx_q   <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            rx_meta_q   <= rx_in;
            rx_s_q      <= rx_meta_q;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;

            // Consumer handshake; a completing frame below takes priority
            if (rx_valid_q && rx_ready) begin
                rx_valid_q   <= 1'b0;
                parity_err_q <= 1'b0;
            end

            if (frame_done_d) begin
                if (!rx_valid_q || rx_ready) begin
                    rx_data_q    <= shift_q;
                    parity_err_q <= perr_d;
                    rx_valid_q   <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end

            if (clk_cnt_q == CNT_S0) samp_q[0] <= rx_s_q;
            if (clk_cnt_q == CNT_S1) samp_q[1] <= rx_s_q;

            if (rx_busy) clk_cnt_q <= bit_end_d ? '0 : clk_cnt_q + CNT_W'(1);

            unique case (state_q)
                S_IDLE: begin
                    if (!rx_s_q) begin
                        state_q   <= S_START;
                        clk_cnt_q <= '0;
                    end
                end
                S_START: begin
                    if (decide_d && vote_d) begin
                        state_q   <= S_IDLE;
                        clk_cnt_q <= '0;
                    end else if (bit_end_d) begin
                        state_q   <= S_DATA;
                        bit_cnt_q <= '0;
                    end
                end
                S_DATA: begin
                    if (decide_d) shift_q <= {vote_d, shift_q[DATA_BITS-1:1]};
                    if (bit_end_d) begin
                        if (bit_cnt_q == BIT_LAST) begin
                            state_q    <= PAR_EN ? S_PARITY : S_STOP;
                            bit_cnt_q  <= '0;
                            stop_idx_q <= 1'b0;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                        end
                    end
                end
                S_PARITY: begin
                    if (decide_d) par_q <= vote_d;
                    if (bit_end_d) begin
                        state_q    <= S_STOP;
                        stop_idx_q <= 1'b0;
                    end
                end
                S_STOP: begin
                    // Last good stop bit returns to IDLE at mid-bit to catch back-to-back starts
                    if (decide_d && !vote_d) begin
                        frame_err_q <= 1'b1;
                        state_q     <= S_WAIT_HIGH;
                        clk_cnt_q   <= '0;
                    end else if (decide_d && last_stop_d) begin
                        state_q   <= S_IDLE;
                        clk_cnt_q <= '0;
                    end else if (bit_end_d) begin
                        stop_idx_q <= 1'b1;
                    end
                end
                S_WAIT_HIGH: begin
                    if (rx_s_q) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rx_busy    = (state_q == S_START) || (state_q == S_DATA) ||
                        (state_q == S_PARITY) || (state_q == S_STOP);
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: three instances (8N1, 7E1, 8N2) at 16 clocks per bit.
module tb_uart_rx_cfg;

    localparam int unsigned CPB = 16;

    logic       clk;
    logic       rst;
    logic       soft_rst;
    logic [2:0] rx_l;
    logic [2:0] rdy;
    logic [7:0] data_a;
    logic [6:0] data_b;
    logic [7:0] data_c;
    logic [2:0] vld, perr, fe, ov, busy;
    logic [8:0] dat [3];

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
        .clk(clk), .rst(rst), .soft_rst(soft_rst), .rx_in(rx_l[0]), .rx_ready(rdy[0]),
        .rx_data(data_a), .rx_valid(vld[0]), .parity_err(perr[0]), .frame_err(fe[0]),
        .overrun(ov[0]), .rx_busy(busy[0]));

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u_b (
        .clk(clk), .rst(rst), .soft_rst(soft_rst), .rx_in(rx_l[1]), .rx_ready(rdy[1]),
        .rx_data(data_b), .rx_valid(vld[1]), .parity_err(perr[1]), .frame_err(fe[1]),
        .overrun(ov[1]), .rx_busy(busy[1]));

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_c (
        .clk(clk), .rst(rst), .soft_rst(soft_rst), .rx_in(rx_l[2]), .rx_ready(rdy[2]),
        .rx_data(data_c), .rx_valid(vld[2]), .parity_err(perr[2]), .frame_err(fe[2]),
        .overrun(ov[2]), .rx_busy(busy[2]));

    always_comb begin
        dat[0] = {1'b0, data_a};
        dat[1] = {2'b0, data_b};
        dat[2] = {1'b0, data_c};
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         checks   = 0;
    int         failures = 0;
    int         wcnt   [3] = '{0, 0, 0};
    int         vcyc   [3] = '{0, 0, 0};
    int         fe_cnt [3] = '{0, 0, 0};
    int         ov_cnt [3] = '{0, 0, 0};
    logic [8:0] wlast  [3] = '{9'h0, 9'h0, 9'h0};
    logic [8:0] wprev  [3] = '{9'h0, 9'h0, 9'h0};
    logic       wperr  [3] = '{1'b0, 1'b0, 1'b0};
    logic [2:0] vld_prev = 3'b0;

    // Capture each new word on its rx_valid rising edge and count pulses
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (vld[i] && !vld_prev[i]) begin
                wprev[i] = wlast[i];
                wlast[i] = dat[i];
                wperr[i] = perr[i];
                wcnt[i]++;
            end
            if (vld[i]) vcyc[i]++;
            if (fe[i])  fe_cnt[i]++;
            if (ov[i])  ov_cnt[i]++;
        end
        vld_prev = vld;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic set_rx(input int d, input logic v);
        rx_l[d] = v;
    endtask

    task automatic send_bit(input int d, input logic v, input bit glitch);
        for (int c = 0; c < CPB; c++) begin
            @(posedge clk);
            #1;
            set_rx(d, (glitch && c == 9) ? ~v : v);
        end
    endtask

    function automatic int nbits_of(input int d);
        return (d == 1) ? 7 : 8;
    endfunction

    task automatic send_frame(input int d, input logic [8:0] data, input bit flip,
                              input int gbit, input logic stopv);
        logic p;
        int   nb;
        nb = nbits_of(d);
        p  = 1'b0;
        send_bit(d, 1'b0, 1'b0);
        for (int i = 0; i < nb; i++) begin
            send_bit(d, data[i], gbit == i);
            p ^= data[i];
        end
        if (d == 1) send_bit(d, p ^ flip, 1'b0);
        for (int s = 0; s < ((d == 2) ? 2 : 1); s++) send_bit(d, stopv, 1'b0);
    endtask

    typedef struct {
        int         d;
        logic [8:0] data;
        bit         flip;
        int         gbit;
        logic [8:0] exp_data;
        logic       exp_perr;
    } vec_t;

    vec_t vecs [11];

    initial begin
        int w0, f0, o0, v0;

        vecs[0]  = '{0, 9'h0A5, 1'b0, -1, 9'h0A5, 1'b0};
        vecs[1]  = '{0, 9'h03C, 1'b0, -1, 9'h03C, 1'b0};
        vecs[2]  = '{0, 9'h000, 1'b0, -1, 9'h000, 1'b0};
        vecs[3]  = '{0, 9'h0FF, 1'b0, -1, 9'h0FF, 1'b0};
        vecs[4]  = '{0, 9'h008, 1'b0,  3, 9'h008, 1'b0};
        vecs[5]  = '{1, 9'h035, 1'b0, -1, 9'h035, 1'b0};
        vecs[6]  = '{1, 9'h035, 1'b1, -1, 9'h035, 1'b1};
        vecs[7]  = '{1, 9'h07F, 1'b0, -1, 9'h07F, 1'b0};
        vecs[8]  = '{1, 9'h001, 1'b1, -1, 9'h001, 1'b1};
        vecs[9]  = '{2, 9'h0F0, 1'b0, -1, 9'h0F0, 1'b0};
        vecs[10] = '{2, 9'h05A, 1'b0,  3, 9'h05A, 1'b0};

        rst      = 1'b0;
        soft_rst = 1'b0;
        rx_l     = 3'b111;
        rdy      = 3'b111;
        idle(4);
        settle();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_data[%0d]", i),  32'(dat[i]),  32'h0);
            check($sformatf("reset_valid[%0d]", i), 32'(vld[i]),  32'h0);
            check($sformatf("reset_perr[%0d]", i),  32'(perr[i]), 32'h0);
            check($sformatf("reset_ferr[%0d]", i),  32'(fe[i]),   32'h0);
            check($sformatf("reset_ovr[%0d]", i),   32'(ov[i]),   32'h0);
            check($sformatf("reset_busy[%0d]", i),  32'(busy[i]), 32'h0);
        end
        rst = 1'b1;
        idle(8);

        for (int k = 0; k < 11; k++) begin
            w0 = wcnt[vecs[k].d];
            f0 = fe_cnt[vecs[k].d];
            o0 = ov_cnt[vecs[k].d];
            v0 = vcyc[vecs[k].d];
            send_frame(vecs[k].d, vecs[k].data, vecs[k].flip, vecs[k].gbit, 1'b1);
            idle(8);
            settle();
            check($sformatf("vec%0d_words", k), 32'(wcnt[vecs[k].d] - w0), 32'd1);
            check($sformatf("vec%0d_data", k),  32'(wlast[vecs[k].d]), 32'(vecs[k].exp_data));
            check($sformatf("vec%0d_perr", k),  32'(wperr[vecs[k].d]), 32'(vecs[k].exp_perr));
            check($sformatf("vec%0d_vcyc", k),  32'(vcyc[vecs[k].d] - v0), 32'd1);
            check($sformatf("vec%0d_ferr", k),  32'(fe_cnt[vecs[k].d] - f0), 32'd0);
            check($sformatf("vec%0d_ovr", k),   32'(ov_cnt[vecs[k].d] - o0), 32'd0);
        end

        // False start: 4 low cycles, then a real frame
        w0 = wcnt[0];
        f0 = fe_cnt[0];
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            set_rx(0, 1'b0);
        end
        @(posedge clk);
        #1;
        set_rx(0, 1'b1);
        settle();
        settle();
        check("false_start_busy_hi", 32'(busy[0]), 32'd1);
        idle(20);
        settle();
        check("false_start_busy_lo", 32'(busy[0]), 32'd0);
        check("false_start_words",   32'(wcnt[0] - w0), 32'd0);
        check("false_start_ferr",    32'(fe_cnt[0] - f0), 32'd0);
        send_frame(0, 9'h03C, 1'b0, -1, 1'b1);
        idle(8);
        settle();
        check("after_false_words", 32'(wcnt[0] - w0), 32'd1);
        check("after_false_data",  32'(wlast[0]), 32'h3C);

        // Framing error followed by a 5-bit-time break
        w0 = wcnt[0];
        f0 = fe_cnt[0];
        send_frame(0, 9'h055, 1'b0, -1, 1'b0);
        idle(5 * CPB);
        settle();
        check("break_ferr",  32'(fe_cnt[0] - f0), 32'd1);
        check("break_busy",  32'(busy[0]), 32'd0);
        check("break_words", 32'(wcnt[0] - w0), 32'd0);
        check("break_valid", 32'(vld[0]), 32'd0);
        set_rx(0, 1'b1);
        idle(20);
        send_frame(0, 9'h081, 1'b0, -1, 1'b1);
        idle(8);
        settle();
        check("after_break_words", 32'(wcnt[0] - w0), 32'd1);
        check("after_break_data",  32'(wlast[0]), 32'h81);
        check("after_break_ferr",  32'(fe_cnt[0] - f0), 32'd1);

        // Overrun with consumer stalled
        rdy[0] = 1'b0;
        w0 = wcnt[0];
        o0 = ov_cnt[0];
        send_frame(0, 9'h011, 1'b0, -1, 1'b1);
        idle(8);
        send_frame(0, 9'h022, 1'b0, -1, 1'b1);
        idle(8);
        settle();
        check("ovr_data",  32'(dat[0]), 32'h11);
        check("ovr_valid", 32'(vld[0]), 32'd1);
        check("ovr_pulse", 32'(ov_cnt[0] - o0), 32'd1);
        check("ovr_words", 32'(wcnt[0] - w0), 32'd1);
        rdy[0] = 1'b1;
        settle();
        settle();
        check("ovr_drain_valid", 32'(vld[0]), 32'd0);
        check("ovr_drain_data",  32'(dat[0]), 32'h11);
        check("ovr_drain_pulse", 32'(ov_cnt[0] - o0), 32'd1);

        // Back-to-back frames with two stop bits
        w0 = wcnt[2];
        f0 = fe_cnt[2];
        send_frame(2, 9'h0F0, 1'b0, -1, 1'b1);
        send_frame(2, 9'h00F, 1'b0, -1, 1'b1);
        idle(8);
        settle();
        check("b2b_words",  32'(wcnt[2] - w0), 32'd2);
        check("b2b_first",  32'(wprev[2]), 32'hF0);
        check("b2b_second", 32'(wlast[2]), 32'h0F);
        check("b2b_ferr",   32'(fe_cnt[2] - f0), 32'd0);

        // soft_rst in the middle of data bit 3
        w0 = wcnt[2];
        f0 = fe_cnt[2];
        send_bit(2, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(2, 1'(i % 2), 1'b0);
        idle(5);
        #1;
        soft_rst = 1'b1;
        set_rx(2, 1'b1);
        @(posedge clk);
        #1;
        soft_rst = 1'b0;
        idle(3 * CPB);
        settle();
        check("srst_valid", 32'(vld[2]), 32'd0);
        check("srst_busy",  32'(busy[2]), 32'd0);
        check("srst_data",  32'(dat[2]), 32'h0);
        check("srst_words", 32'(wcnt[2] - w0), 32'd0);
        check("srst_ferr",  32'(fe_cnt[2] - f0), 32'd0);
        send_frame(2, 9'h042, 1'b0, -1, 1'b1);
        idle(8);
        settle();
        check("after_srst_words", 32'(wcnt[2] - w0), 32'd1);
        check("after_srst_data",  32'(wlast[2]), 32'h42);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised UART receiver, the next generation of the team's fixed 8N1 receiver. It supports configurable data width, parity and stop-bit count, and uses 3-sample majority voting at mid-bit. It rejects false starts, recovers from framing errors without external intervention, and delivers bytes through a valid/ready handshake with overrun detection. It sits between the rx pad (asynchronous) and the register/FIFO layer in the clk domain.

Parameters:
CLKS_PER_BIT, 5208, clk cycles per bit; must be >= 8.
DATA_BITS, 8, data bits per frame; legal range 5..9; sent LSB first.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, 1 or 2.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
soft_rst  in  1  synchronous reset, active-high; same effect as rst
rx_in  in  1  serial line, asynchronous, idle high
rx_ready  in  1  consumer accepts rx_data when rx_valid && rx_ready
rx_data  out  DATA_BITS  received word
rx_valid  out  1  rx_data holds an unconsumed word
parity_err  out  1  qualifies the current rx_data; valid while rx_valid=1
frame_err  out  1  one-cycle pulse; stop bit sampled 0
overrun  out  1  one-cycle pulse; a frame completed while rx_valid=1
rx_busy  out  1  high in START, DATA, PARITY and STOP states

Behaviour:
- Reset (rst low, or soft_rst high at a clk edge): state=IDLE, all counters 0, synchroniser flops=1. All outputs are 0, including rx_data.
- rx_in passes through a 2-flop synchroniser (rx_s), giving 2 cycles of latency. Every decision below uses rx_s.
- Bit timing:
  - clk_cnt runs 0..CLKS_PER_BIT-1 and wraps; it is cleared on the IDLE->START transition.
  - Let M = CLKS_PER_BIT/2 (integer division).
  - rx_s is captured at clk_cnt = M-1, M and M+1. The bit value is the majority of the three captures, decided in the cycle clk_cnt = M+1.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE: rx_s=0 moves to START.
- START:
  - At the decision point, a value of 1 is a false start: go to IDLE with no flags.
  - Otherwise, at clk_cnt = CLKS_PER_BIT-1 go to DATA with bit_cnt=0.
- DATA:
  - Each decided bit is shifted in LSB-first.
  - At clk_cnt = CLKS_PER_BIT-1, bit_cnt increments.
  - After bit_cnt reaches DATA_BITS-1 and the bit ends, go to PARITY if PARITY!=0, else STOP.
- PARITY: the decided bit is stored. perr = (XOR of data bits XOR parity bit) != (PARITY==1 ? 1 : 0). At bit end, go to STOP.
- STOP:
  - Decided value 0: pulse frame_err for one cycle, discard the frame, go to WAIT_HIGH.
  - Decided value 1 on the last stop bit: the frame is complete and the state goes to IDLE in that same decision cycle, so the next start edge is accepted at mid-stop-bit.
  - With STOP_BITS=2, the first stop bit waits for its bit end. The second stop bit is then checked identically.
- WAIT_HIGH: stay until rx_s=1, then go to IDLE. This is the break/line-low recovery and there is no sticky error state.
- Completion, taking effect the cycle after the stop decision:
  - If rx_valid=0, or rx_valid && rx_ready in that same cycle: load rx_data and parity_err=perr, and set rx_valid=1.
  - Else: pulse overrun, keep the old rx_data, rx_valid and parity_err, and drop the new word.
- Handshake: rx_valid && rx_ready clears rx_valid and parity_err on the next edge. rx_data holds its value. rx_ready while rx_valid=0 has no effect.
- rx_busy is combinational from state. frame_err and overrun are registered single-cycle pulses.
- soft_rst mid-frame aborts the frame with no flags. A frame then starts only on a new 0 seen in IDLE.
- Width rules: clk_cnt width is $clog2(CLKS_PER_BIT); bit_cnt width is $clog2(DATA_BITS)+1.

Test Plan:
Bench parameters are CLKS_PER_BIT=16 unless stated; frames are driven bit-accurately on rx_in.
- 8N1, send 0xA5, rx_ready=1 -> rx_valid for 1 cycle, rx_data=0xA5, parity_err=0, no frame_err.
- PARITY=2 (even), DATA_BITS=7: send 0x35 with correct parity bit -> parity_err=0. Resend with the parity bit flipped -> rx_valid=1, rx_data=0x35, parity_err=1.
- False start: rx_in low for 4 cycles then high -> returns to IDLE, rx_busy drops, no rx_valid and no flags. A following 0x3C frame is received correctly.
- Framing error plus break: send 0x55 with stop=0 and hold the line low for 5 bit times -> one frame_err pulse, no rx_valid, stays in WAIT_HIGH. A 0x81 frame after the line returns high is received correctly.
- Overrun: rx_ready=0, send 0x11 then 0x22 -> rx_data=0x11, one overrun pulse. Then assert rx_ready -> rx_valid clears.
- STOP_BITS=2 with back-to-back frames 0xF0, 0x0F, plus glitch tolerance:
  - Frames received: both words, in order.
  - Glitch: a single-cycle inverted rx_in at the M sample of bit 3 does not change the data.
  - soft_rst mid-DATA: aborts silently, with rx_valid=0.
